// File: rtl/pipe_nodatahazards_if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Widths, reset PC, bubble encoding, FSM states and queue entry layout.
package pipe_nodatahazards_if_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0340_0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] p4;
   } fq_entry_t;

   // Sequential PC increment; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_add4(
      input logic [XLEN-1:0] pc
   );
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipe_nodatahazards_if_fifo.sv
// Two-entry queue of {inst, p4} between fetch and decode.
// Flush wins over push/pop; push into a full queue is dropped.
module pipe_nodatahazards_if_fifo
   import pipe_nodatahazards_if_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  fq_entry_t  i_data,
   output fq_entry_t  o_head,
   output logic [1:0] o_count
);

   fq_entry_t  r_mem [2];
   logic       r_rd;
   logic       r_wr;
   logic [1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == 2'd2);
   assign w_empty = (r_count == 2'd0);
   assign w_push  = i_push & ~w_full;
   assign w_pop   = i_pop & ~w_empty;

   // Pointer and occupancy update.
   always_ff @(posedge clk) begin
      if (clr || i_flush) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push)
            r_wr <= ~r_wr;
         if (w_pop)
            r_rd <= ~r_rd;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care while unoccupied.
   always_ff @(posedge clk) begin
      if (!clr && !i_flush && w_push)
         r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

endmodule

// File: rtl/pipe_nodatahazards_if.sv
// Instruction-fetch stage: owns fetch PC and imem request port.
// Buffers fetched words in a 2-entry queue and obeys ID stall/redirect.
module pipe_nodatahazards_if
   import pipe_nodatahazards_if_pkg::*;
(
   input  logic            clk,
   input  logic            clr,
   input  logic            IFwip,
   input  logic            IDwillJump,
   input  logic [XLEN-1:0] IDjumpPc,
   input  logic            imemAck,
   input  logic [XLEN-1:0] imemData,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   output logic [XLEN-1:0] IFinst,
   output logic [XLEN-1:0] IFp4
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_fpc;
   logic [XLEN-1:0] w_fpc_nxt;
   logic [XLEN-1:0] r_drop_addr;
   logic [XLEN-1:0] w_drop_nxt;

   logic            w_req;
   logic            w_ack;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_has;
   logic [1:0]      w_count;
   logic [XLEN-1:0] w_fpc_p4;
   fq_entry_t       w_push_data;
   fq_entry_t       w_head;

   assign w_has    = (w_count != 2'd0);
   assign w_fpc_p4 = pc_add4(r_fpc);

   // Request stays up in DROP, and in RUN while the queue has room.
   assign w_req = ~clr & ((r_state == ST_DROP) |
                          ((r_state == ST_RUN) & (w_count != 2'd2)));
   assign w_ack = imemAck & w_req;

   assign imemReq  = w_req;
   assign imemAddr = (r_state == ST_DROP) ? r_drop_addr : r_fpc;

   assign w_pop = IFwip & w_has & ~IDwillJump;

   assign w_push_data.inst = imemData;
   assign w_push_data.p4   = w_fpc_p4;

   // Next fetch PC, drop address, state and queue control.
   always_comb begin
      w_state_nxt = r_state;
      w_fpc_nxt   = r_fpc;
      w_drop_nxt  = r_drop_addr;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (IDwillJump) begin
               w_flush   = 1'b1;
               w_fpc_nxt = IDjumpPc;
               if (w_req && !imemAck) begin
                  w_drop_nxt  = r_fpc;
                  w_state_nxt = ST_DROP;
               end
            end else if (w_ack) begin
               w_push    = 1'b1;
               w_fpc_nxt = w_fpc_p4;
            end
         end
         ST_DROP: begin
            if (IDwillJump) begin
               w_flush   = 1'b1;
               w_fpc_nxt = IDjumpPc;
            end
            if (w_ack)
               w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Fetch-side state registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= ST_RUN;
         r_fpc       <= RESET_PC;
         r_drop_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_fpc       <= w_fpc_nxt;
         r_drop_addr <= w_drop_nxt;
      end
   end

   pipe_nodatahazards_if_fifo u_fifo (
      .clk     (clk),
      .clr     (clr),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign IFinst = (w_has & ~IDwillJump) ? w_head.inst : NOP_INST;
   assign IFp4   = (w_has & ~IDwillJump) ? w_head.p4   : '0;

endmodule

// File: tb/tb_pipe_nodatahazards_if.sv
// Testbench for the fetch stage: vector table, directed corner
// sequences and randomized traffic against a queue-based model.
module tb_pipe_nodatahazards_if;
   import pipe_nodatahazards_if_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic        IFwip;
   logic        IDwillJump;
   logic [31:0] IDjumpPc;
   logic        imemAck;
   logic [31:0] imemData;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] IFinst;
   logic [31:0] IFp4;

   always #5 clk = ~clk;

   pipe_nodatahazards_if dut (
      .clk        (clk),
      .clr        (clr),
      .IFwip      (IFwip),
      .IDwillJump (IDwillJump),
      .IDjumpPc   (IDjumpPc),
      .imemAck    (imemAck),
      .imemData   (imemData),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .IFinst     (IFinst),
      .IFp4       (IFp4)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_fpc;
   logic [31:0] m_daddr;
   bit          m_drop;
   logic [63:0] m_q[$];

   typedef struct {
      bit          c;
      bit          w;
      bit          j;
      logic [31:0] jp;
      bit          a;
      logic [31:0] d;
      bit          er;
      logic [31:0] ea;
      logic [31:0] ei;
      logic [31:0] ep;
   } vec_t;

   vec_t tv[10];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_req();
      return m_drop || (m_q.size() < 2);
   endfunction

   task automatic model_step(input bit c, input bit w, input bit j,
                             input logic [31:0] jp, input bit a,
                             input logic [31:0] d);
      bit rq;
      bit ak;
      if (c) begin
         m_fpc   = RESET_PC;
         m_daddr = '0;
         m_drop  = 1'b0;
         m_q.delete();
         return;
      end
      rq = m_req();
      ak = a && rq;
      if (!m_drop) begin
         if (j) begin
            if (rq && !ak) begin
               m_daddr = m_fpc;
               m_drop  = 1'b1;
            end
            m_q.delete();
            m_fpc = jp;
         end else begin
            if (w && m_q.size() > 0)
               void'(m_q.pop_front());
            if (ak) begin
               m_q.push_back({d, m_fpc + 32'd4});
               m_fpc = m_fpc + 32'd4;
            end
         end
      end else begin
         if (j) begin
            m_q.delete();
            m_fpc = jp;
         end else if (w && m_q.size() > 0) begin
            void'(m_q.pop_front());
         end
         if (ak)
            m_drop = 1'b0;
      end
   endtask

   // One clock: drive at negedge, compare against model, advance model.
   task automatic cyc(input bit c, input bit w, input bit j,
                      input logic [31:0] jp, input bit a,
                      input logic [31:0] d);
      bit          rq;
      logic [31:0] ei;
      logic [31:0] ep;
      @(negedge clk);
      clr        = c;
      IFwip      = w;
      IDwillJump = j;
      IDjumpPc   = jp;
      imemAck    = a;
      imemData   = d;
      #1;
      rq = !c && m_req();
      chk("req", {31'b0, imemReq}, {31'b0, rq});
      if (rq)
         chk("addr", imemAddr, m_drop ? m_daddr : m_fpc);
      if (m_q.size() > 0 && !j) begin
         ei = m_q[0][63:32];
         ep = m_q[0][31:0];
      end else begin
         ei = NOP_INST;
         ep = '0;
      end
      chk("inst", IFinst, ei);
      chk("p4", IFp4, ep);
      model_step(c, w, j, jp, a, d);
   endtask

   task automatic rst();
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      bit          c;
      bit          w;
      bit          j;
      bit          a;
      logic [31:0] jp;
      logic [31:0] d;

      clr        = 1'b1;
      IFwip      = 1'b0;
      IDwillJump = 1'b0;
      IDjumpPc   = '0;
      imemAck    = 1'b0;
      imemData   = '0;
      repeat (2) @(posedge clk);
      model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Stall with queue saturation, then drain in order.
      tv[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b0, 32'h0, NOP_INST, 32'h0};
      tv[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111,
                1'b1, 32'h0, NOP_INST, 32'h0};
      tv[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222,
                1'b1, 32'h4, 32'h1111_1111, 32'h4};
      tv[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b0, 32'h0, 32'h1111_1111, 32'h4};
      tv[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999,
                1'b0, 32'h0, 32'h1111_1111, 32'h4};
      tv[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b0, 32'h0, 32'h1111_1111, 32'h4};
      tv[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b0, 32'h0, 32'h1111_1111, 32'h4};
      tv[7] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333,
                1'b1, 32'h8, 32'h2222_2222, 32'h8};
      tv[8] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b1, 32'hC, 32'h3333_3333, 32'hC};
      tv[9] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                1'b1, 32'hC, NOP_INST, 32'h0};
      for (int i = 0; i < 10; i++) begin
         cyc(tv[i].c, tv[i].w, tv[i].j, tv[i].jp, tv[i].a, tv[i].d);
         chk($sformatf("tv%0d_req", i), {31'b0, imemReq}, {31'b0, tv[i].er});
         if (tv[i].er)
            chk($sformatf("tv%0d_addr", i), imemAddr, tv[i].ea);
         chk($sformatf("tv%0d_inst", i), IFinst, tv[i].ei);
         chk($sformatf("tv%0d_p4", i), IFp4, tv[i].ep);
      end

      // Zero-wait memory, constant pop: one instruction per cycle.
      rst();
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, memf(32'(4 * (k - 1))));
         chk("tp_addr", imemAddr, 32'(4 * (k - 1)));
         if (k >= 2) begin
            chk("tp_inst", IFinst, memf(32'(4 * (k - 2))));
            chk("tp_p4", IFp4, 32'(4 * (k - 1)));
         end
      end

      // Slow memory, redirect while request pending.
      rst();
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("slow_a0", imemAddr, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
      chk("slow_jnop", IFinst, NOP_INST);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("slow_hold", imemAddr, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
      chk("slow_hold2", imemAddr, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("slow_tgt", imemAddr, 32'h100);
      chk("slow_nop", IFinst, NOP_INST);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0100_AAAA);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("slow_inst", IFinst, 32'h0100_AAAA);
      chk("slow_p4", IFp4, 32'h104);

      // Jump coinciding with ack and a non-empty queue.
      rst();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_0000);
      cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h4444_0004);
      chk("ja_nop", IFinst, NOP_INST);
      chk("ja_p4", IFp4, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
      chk("ja_addr", imemAddr, 32'h500);
      chk("ja_nop2", IFinst, NOP_INST);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("ja_inst", IFinst, 32'h5555_5555);
      chk("ja_p4b", IFp4, 32'h504);

      // Two jumps during DROP: only the last target is fetched.
      rst();
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
      chk("dd_hold", imemAddr, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0300_0300);
      chk("dd_addr", imemAddr, 32'h300);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("dd_inst", IFinst, 32'h0300_0300);
      chk("dd_p4", IFp4, 32'h304);

      // Reset asserted mid-DROP.
      rst();
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      chk("cd_req", {31'b0, imemReq}, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("cd_req1", {31'b0, imemReq}, 32'h1);
      chk("cd_addr", imemAddr, RESET_PC);
      chk("cd_inst", IFinst, NOP_INST);

      // PC wrap at the top of the address space.
      rst();
      cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hF00D_F00D);
      chk("wr_addr", imemAddr, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("wr_inst", IFinst, 32'hF00D_F00D);
      chk("wr_p4", IFp4, 32'h0);
      chk("wr_next", imemAddr, 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         c  = ($urandom % 200) == 0;
         w  = ($urandom % 4) != 0;
         j  = ($urandom % 10) == 0;
         jp = $urandom;
         jp[1:0] = 2'b00;
         if (($urandom % 4) == 0)
            jp[31:8] = '1;
         if (m_req())
            a = ($urandom % 3) != 0;
         else
            a = ($urandom % 8) == 0;
         d = $urandom;
         cyc(c, w, j, jp, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
